// File: rtl/counter_prog_pkg.sv
// Shared types and constants for the programmable counter.
// Provides the mode/direction enums and the boundary-event codes used between
// the next-state calculator and the top-level register stage.
package counter_prog_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
    typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_e;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_NONE = 2'd0;
    localparam ev_code_t EV_OVF  = 2'd1;
    localparam ev_code_t EV_UDF  = 2'd2;

endpackage

// File: rtl/counter_prog_next.sv
// Combinational next-count calculator for the programmable counter.
// Ports:
//   count      current count
//   min_val    lower bound (inclusive)
//   max_val    upper bound (inclusive)
//   step       step magnitude; zero means hold with no event
//   dir        count direction
//   mode       wrap or saturate on a boundary event
//   next_count count after one enabled step
//   ev         boundary event code (EV_NONE/EV_OVF/EV_UDF)
module counter_prog_next
    import counter_prog_pkg::*;
#(
    parameter int unsigned COUNT_WD = 16,
    parameter int unsigned STEP_WD  = 4
) (
    input  logic [COUNT_WD-1:0] count,
    input  logic [COUNT_WD-1:0] min_val,
    input  logic [COUNT_WD-1:0] max_val,
    input  logic [STEP_WD-1:0]  step,
    input  cnt_dir_e            dir,
    input  cnt_mode_e           mode,
    output logic [COUNT_WD-1:0] next_count,
    output ev_code_t            ev
);

    localparam int unsigned EW = COUNT_WD + 1;

    // One extra bit keeps the sum free of native wrap and lets the
    // difference go negative so it can be compared against min signed.
    logic [EW-1:0] count_ext;
    logic [EW-1:0] step_ext;
    logic [EW-1:0] min_ext;
    logic [EW-1:0] max_ext;
    logic [EW-1:0] sum;
    logic [EW-1:0] diff;

    assign count_ext = {1'b0, count};
    assign step_ext  = EW'(step);
    assign min_ext   = {1'b0, min_val};
    assign max_ext   = {1'b0, max_val};
    assign sum       = count_ext + step_ext;
    assign diff      = count_ext - step_ext;

    always_comb begin
        next_count = count;
        ev         = EV_NONE;
        if (step != '0) begin
            if (dir == CNT_UP) begin
                if (sum > max_ext) begin
                    ev         = EV_OVF;
                    next_count = (mode == CNT_WRAP) ? min_val : max_val;
                end else begin
                    next_count = sum[COUNT_WD-1:0];
                end
            end else begin
                if ($signed(diff) < $signed(min_ext)) begin
                    ev         = EV_UDF;
                    next_count = (mode == CNT_WRAP) ? max_val : min_val;
                end else begin
                    next_count = diff[COUNT_WD-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with runtime bounds, step, wrap/saturate mode,
// synchronous load/clear, terminal-count pulse and sticky boundary flags.
// Ports:
//   i_clk, i_rstb    clock, asynchronous active-low reset
//   i_clr            synchronous clear to i_min, clears flags (highest priority)
//   i_load           synchronous load of i_load_val clamped to [i_min, i_max]
//   i_en, i_dir      count enable, direction (1 = up)
//   i_mode           0 = wrap, 1 = saturate
//   i_min, i_max     inclusive bounds; i_step step magnitude
//   i_flag_clr       clears o_ovf/o_udf (a same-cycle event wins)
//   o_count          registered count
//   o_tc             one-cycle pulse after each boundary event
//   o_ovf, o_udf     sticky upward/downward event flags
//   o_cfg_err        registered i_min > i_max
module counter_prog
    import counter_prog_pkg::*;
#(
    parameter int unsigned COUNT_WD = 16,
    parameter int unsigned STEP_WD  = 4,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic                i_clk,
    input  logic                i_rstb,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic                i_dir,
    input  logic                i_mode,
    input  logic                i_load,
    input  logic [COUNT_WD-1:0] i_load_val,
    input  logic [COUNT_WD-1:0] i_min,
    input  logic [COUNT_WD-1:0] i_max,
    input  logic [STEP_WD-1:0]  i_step,
    input  logic                i_flag_clr,
    output logic [COUNT_WD-1:0] o_count,
    output logic                o_tc,
    output logic                o_ovf,
    output logic                o_udf,
    output logic                o_cfg_err
);

    logic [COUNT_WD-1:0] count_q, count_d;
    logic                tc_q, tc_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                cfg_err_q, cfg_err_d;

    logic                cfg_bad;
    logic [COUNT_WD-1:0] next_count;
    ev_code_t            ev;

    counter_prog_next #(
        .COUNT_WD (COUNT_WD),
        .STEP_WD  (STEP_WD)
    ) u_next (
        .count      (count_q),
        .min_val    (i_min),
        .max_val    (i_max),
        .step       (i_step),
        .dir        (cnt_dir_e'(i_dir)),
        .mode       (cnt_mode_e'(i_mode)),
        .next_count (next_count),
        .ev         (ev)
    );

    // Bad bounds block load/enable in the same cycle they are presented, so
    // a clamp or step is never evaluated against an inverted range.
    assign cfg_bad = (i_min > i_max);

    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        cfg_err_d = cfg_bad;

        if (i_flag_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (i_clr) begin
            count_d = i_min;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (!cfg_bad) begin
            if (i_load) begin
                if (i_load_val < i_min) begin
                    count_d = i_min;
                end else if (i_load_val > i_max) begin
                    count_d = i_max;
                end else begin
                    count_d = i_load_val;
                end
            end else if (i_en) begin
                count_d = next_count;
                // Set overrides a same-cycle flag clear.
                if (ev == EV_OVF) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else if (ev == EV_UDF) begin
                    tc_d  = 1'b1;
                    udf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            count_q   <= COUNT_WD'(RST_VAL);
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign o_count   = count_q;
    assign o_tc      = tc_q;
    assign o_ovf     = ovf_q;
    assign o_udf     = udf_q;
    assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_counter_prog.sv
// Directed self-checking bench for counter_prog with hand-computed expectations.
module tb_counter_prog;

    logic        clk;
    logic        rstb;
    logic        clr;
    logic        en;
    logic        dir;
    logic        mode;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] min_v;
    logic [15:0] max_v;
    logic [3:0]  step;
    logic        flag_clr;
    logic [15:0] count;
    logic        tc;
    logic        ovf;
    logic        udf;
    logic        cfg_err;

    int n_total = 0;
    int n_bad   = 0;

    counter_prog #(
        .COUNT_WD (16),
        .STEP_WD  (4),
        .RST_VAL  (0)
    ) dut (
        .i_clk      (clk),
        .i_rstb     (rstb),
        .i_clr      (clr),
        .i_en       (en),
        .i_dir      (dir),
        .i_mode     (mode),
        .i_load     (load),
        .i_load_val (load_val),
        .i_min      (min_v),
        .i_max      (max_v),
        .i_step     (step),
        .i_flag_clr (flag_clr),
        .o_count    (count),
        .o_tc       (tc),
        .o_ovf      (ovf),
        .o_udf      (udf),
        .o_cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b0; clr = 1'b0; en = 1'b0; dir = 1'b1; mode = 1'b0; load = 1'b0;
        load_val = '0; min_v = 16'd0; max_v = 16'd15; step = 4'd1; flag_clr = 1'b0;

        #3;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_tc", 32'(tc), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        check_eq("rst_udf", 32'(udf), 0);
        check_eq("rst_cfg_err", 32'(cfg_err), 0);

        @(negedge clk);
        rstb = 1'b1;

        // Up by 1 for five cycles
        check_eq("up_count0", 32'(count), 0);
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("up_count", 32'(count), 32'(i));
            check_eq("up_tc", 32'(tc), 0);
        end
        en = 1'b0;

        // Wrap overflow, then flag clear
        mode = 1'b0; dir = 1'b1; step = 4'd3; min_v = 16'd2; max_v = 16'd10;
        load_val = 16'd9; load = 1'b1;
        tick();
        check_eq("wrap_load", 32'(count), 9);
        load = 1'b0; en = 1'b1;
        tick();
        check_eq("wrap_count", 32'(count), 2);
        check_eq("wrap_tc", 32'(tc), 1);
        check_eq("wrap_ovf", 32'(ovf), 1);
        en = 1'b0; flag_clr = 1'b1;
        tick();
        check_eq("flagclr_ovf", 32'(ovf), 0);
        check_eq("flagclr_tc", 32'(tc), 0);
        flag_clr = 1'b0;

        // Saturating underflow repeats each cycle
        mode = 1'b1; dir = 1'b0; step = 4'd4; min_v = 16'd5; max_v = 16'd20;
        load_val = 16'd7; load = 1'b1;
        tick();
        check_eq("sat_load", 32'(count), 7);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("sat_count", 32'(count), 5);
            check_eq("sat_tc", 32'(tc), 1);
            check_eq("sat_udf", 32'(udf), 1);
        end
        en = 1'b0;
        tick();
        check_eq("sat_tc_off", 32'(tc), 0);
        check_eq("sat_udf_sticky", 32'(udf), 1);

        // Load clamp and clear-over-load priority
        min_v = 16'd0; max_v = 16'd100; load_val = 16'hFFFF; load = 1'b1;
        tick();
        check_eq("load_clamp", 32'(count), 100);
        min_v = 16'd3; load_val = 16'd50; clr = 1'b1;
        tick();
        check_eq("clr_prio_count", 32'(count), 3);
        check_eq("clr_udf", 32'(udf), 0);
        clr = 1'b0; load = 1'b0;

        // Inverted bounds
        min_v = 16'd50; max_v = 16'd10;
        tick();
        check_eq("cfg_err_set", 32'(cfg_err), 1);
        check_eq("cfg_hold0", 32'(count), 3);
        en = 1'b1; load = 1'b1; load_val = 16'd7; dir = 1'b1; step = 4'd1;
        tick();
        tick();
        check_eq("cfg_hold", 32'(count), 3);
        check_eq("cfg_err_hi", 32'(cfg_err), 1);
        en = 1'b0; load = 1'b0; clr = 1'b1;
        tick();
        check_eq("cfg_clr", 32'(count), 50);
        clr = 1'b0; min_v = 16'd0; max_v = 16'd100;
        tick();
        check_eq("cfg_err_clr", 32'(cfg_err), 0);
        check_eq("cfg_restore_cnt", 32'(count), 50);

        // Zero step holds without event
        en = 1'b1; step = 4'd0; dir = 1'b1;
        tick();
        check_eq("step0_count", 32'(count), 50);
        check_eq("step0_tc", 32'(tc), 0);

        // min == max: any nonzero step is an event
        min_v = 16'd50; max_v = 16'd50; step = 4'd2; mode = 1'b0;
        tick();
        check_eq("eq_count", 32'(count), 50);
        check_eq("eq_tc", 32'(tc), 1);
        check_eq("eq_ovf", 32'(ovf), 1);
        en = 1'b0;

        // Async reset mid-count
        min_v = 16'd0; max_v = 16'd100; step = 4'd1; dir = 1'b1; mode = 1'b0;
        load_val = 16'd37; load = 1'b1;
        tick();
        check_eq("ar_load", 32'(count), 37);
        load = 1'b0; en = 1'b1;
        rstb = 1'b0;
        #1;
        check_eq("ar_count", 32'(count), 0);
        check_eq("ar_ovf", 32'(ovf), 0);
        check_eq("ar_tc", 32'(tc), 0);
        #2;
        rstb = 1'b1;
        tick();
        check_eq("ar_resume", 32'(count), 1);

        // Overflow wins over same-cycle flag clear
        en = 1'b0; load_val = 16'd99; load = 1'b1;
        tick();
        check_eq("fc_load", 32'(count), 99);
        load = 1'b0; en = 1'b1; step = 4'd3; flag_clr = 1'b1;
        tick();
        check_eq("fc_count", 32'(count), 0);
        check_eq("fc_ovf", 32'(ovf), 1);
        check_eq("fc_tc", 32'(tc), 1);
        flag_clr = 1'b0;

        // Down from below min, then up from above max
        min_v = 16'd10; max_v = 16'd20; dir = 1'b0; step = 4'd1;
        tick();
        check_eq("below_min_cnt", 32'(count), 20);
        check_eq("below_min_udf", 32'(udf), 1);
        check_eq("below_min_tc", 32'(tc), 1);
        max_v = 16'd15; dir = 1'b1; mode = 1'b1;
        tick();
        check_eq("above_max_cnt", 32'(count), 15);
        check_eq("above_max_tc", 32'(tc), 1);
        en = 1'b0;
        tick();
        check_eq("final_tc", 32'(tc), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_prog.md
Name: counter_prog

Overview:
Programmable up/down counter and successor to the fixed free-running counter. Adds:
- runtime min/max bounds and step size
- wrap or saturate mode
- synchronous load and clear
- terminal-count pulse, plus sticky overflow/underflow flags

Used as the general-purpose timer/index generator in the demo designs. The cocotb wrapper instantiates it in the same way it instantiates the existing counter.

Parameters:
COUNT_WD, 16, width of count, bounds and load value (>=2)
STEP_WD, 4, width of step input (1..COUNT_WD)
RST_VAL, 0, reset value of o_count (must fit COUNT_WD)

Ports:
i_clk  in  1  clock; all logic rising-edge
i_rstb  in  1  asynchronous active-low reset
i_clr  in  1  synchronous clear: count <= i_min, flags cleared
i_en  in  1  count enable
i_dir  in  1  1 = up, 0 = down
i_mode  in  1  0 = wrap, 1 = saturate
i_load  in  1  synchronous load of i_load_val
i_load_val  in  COUNT_WD  load value
i_min  in  COUNT_WD  lower bound (inclusive)
i_max  in  COUNT_WD  upper bound (inclusive)
i_step  in  STEP_WD  increment/decrement magnitude
i_flag_clr  in  1  clears o_ovf/o_udf
o_count  out  COUNT_WD  current count (registered)
o_tc  out  1  one-cycle pulse on boundary event (registered)
o_ovf  out  1  sticky: upward boundary event occurred
o_udf  out  1  sticky: downward boundary event occurred
o_cfg_err  out  1  i_min > i_max (registered)

Behaviour:
- Reset (i_rstb low, async): o_count = RST_VAL, o_tc = 0, o_ovf = 0, o_udf = 0, o_cfg_err = 0. Release is synchronous to i_clk.
- All outputs are registered. An action sampled at edge N is visible after edge N.
- Priority per cycle: i_clr > i_load > i_en > hold.
- Clear: count <= i_min; o_ovf, o_udf <= 0; o_tc <= 0.
- Load: count <= i_load_val clamped to [i_min, i_max]. No flags, o_tc <= 0.
- Enabled up:
  - sum = count + step, computed in COUNT_WD+1 bits so there is no native wrap.
  - sum <= i_max: count <= sum, no event.
  - sum > i_max: overflow event. Wrap mode: count <= i_min (remainder discarded). Saturate mode: count <= i_max.
- Enabled down:
  - diff = count - step, computed in COUNT_WD+1 bits signed.
  - diff >= i_min: count <= diff.
  - diff < i_min: underflow event. Wrap mode: count <= i_max. Saturate mode: count <= i_min.
- Saturated and still enabled toward the bound: the event repeats every cycle, so o_tc pulses each cycle and count holds.
- i_step = 0 with i_en: count holds, no event.
- Event handling:
  - o_tc = 1 for exactly the cycle after each event.
  - The sticky flag for the event direction is set.
  - If i_flag_clr is asserted in the same cycle as a set event, the set wins.
- i_min == i_max: any nonzero step is an event; count stays at that value.
- o_cfg_err tracks (i_min > i_max) each cycle. While it is high: load and enable are ignored, count holds, and clear still sets count to i_min.
- Count outside [i_min, i_max] after a bound change: the next enabled step is evaluated by the rules above. Up from above max, or down from below min, is an event.
- i_dir, i_mode and i_step may change any cycle. They take effect on the next enabled edge.

Decomposition:
- Package counter_prog_pkg:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e
  - typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_e
  - localparam event codes EV_NONE/EV_OVF/EV_UDF
- Sub-module counter_prog_next: purely combinational. Takes count, bounds, step, dir and mode. Returns next_count and event code.
- The top holds only registers, priority muxing and flags.

Test Plan:
- Reset then 5 enabled cycles, up, step 1, min 0, max 15 -> o_count 0,1,2,3,4,5; o_tc stays 0.
- Wrap, up, step 3, min 2, max 10, load 9, enable 1 cycle -> count 2, o_tc pulse, o_ovf = 1; i_flag_clr -> o_ovf = 0 next cycle.
- Saturate, down, step 4, min 5, max 20, count 7, enable 3 cycles -> count 5,5,5; o_tc high 3 cycles; o_udf = 1.
- Load 0xFFFF with min 0, max 100 -> count 100. Same cycle i_clr = 1 and i_load = 1 -> count = i_min.
- i_min = 50, i_max = 10 -> o_cfg_err = 1, enable/load ignored, count holds. Restore bounds -> o_cfg_err = 0 next cycle.
- Async reset asserted mid-count at count 37 -> outputs reset immediately without a clock edge. Release -> counting resumes from RST_VAL. i_flag_clr with a simultaneous overflow -> o_ovf = 1.
